activation_unit: RTL and testbench

- Pipelined, parametrised successor to the lane-parallel ReLU stage; sits between the systolic-array accumulator outputs and the next-layer buffer.
- Each of LENGTH lanes takes a wide signed accumulator value, requantises it (rounding arithmetic right shift with saturation), then applies a selectable activation: identity, ReLU, leaky ReLU or clamped ReLU.
- Uses a valid/ready handshake with full backpressure.
- Configuration is captured per beat, so a mode change never corrupts beats already in flight.

---
 rtl/activation_unit.sv | 184 ++++++++++++++++++
 tb/tb_activation_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/activation_unit.sv
// activation_unit: lane-parallel requantise + activation stage.
// Each lane takes a wide signed accumulator value, applies a rounding
// arithmetic right shift with saturation (stage S1), then applies the
// selected activation (stage S2). A valid/ready handshake with full
// backpressure joins the two stages. Configuration travels with each beat.

module activation_unit #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int LENGTH      = 4,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  In [0:LENGTH-1],
  input  logic [1:0]                  mode,
  input  logic [SHIFT_WIDTH-1:0]      shift,
  input  logic [SHIFT_WIDTH-1:0]      leak_shift,
  input  logic signed [OUT_WIDTH-1:0] clip_max,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] Out [0:LENGTH-1],
  output logic                        out_sat
);

  typedef enum logic [1:0] {
    MODE_IDENT = 2'b00,
    MODE_RELU  = 2'b01,
    MODE_LEAKY = 2'b10,
    MODE_CLAMP = 2'b11
  } act_mode_e;

  // Saturation bounds expressed at the widened requantisation width.
  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    $signed({{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

  // Rounding arithmetic right shift, one bit wider than the input so the
  // half-LSB bias can never wrap. Ties round toward +inf.
  function automatic logic signed [IN_WIDTH:0] round_shift(
    input logic signed [IN_WIDTH-1:0] x,
    input logic [SHIFT_WIDTH-1:0]     sh
  );
    logic signed [IN_WIDTH:0] xe;
    logic signed [IN_WIDTH:0] bias;
    xe = {x[IN_WIDTH-1], x};
    if (sh == '0) begin
      return xe;
    end
    bias = (IN_WIDTH+1)'(1) << (sh - 1'b1);
    return (xe + bias) >>> sh;
  endfunction

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  // Stage advance terms; each stage moves when it is empty or the stage
  // after it is moving. in_ready never depends on in_valid.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
  end

  assign out_valid = s2_valid;

  // ------------------------------------------------------------------
  // S1: requantise
  // ------------------------------------------------------------------
  logic signed [OUT_WIDTH-1:0] rq_y   [0:LENGTH-1];
  logic [LENGTH-1:0]           rq_sat;

  // Per-lane rounding shift followed by saturation to the output range.
  always_comb begin
    logic signed [IN_WIDTH:0] r;
    // NOTE: every output of this block is assigned a default before any
    // branch so no path leaves a value held, which would infer a latch.
    rq_sat = '0;
    r      = '0;
    for (int i = 0; i < LENGTH; i++) begin
      rq_y[i] = '0;
      r = round_shift(In[i], shift);
      if (r > SAT_MAX) begin
        rq_y[i]   = SAT_MAX[OUT_WIDTH-1:0];
        rq_sat[i] = 1'b1;
      end else if (r < SAT_MIN) begin
        rq_y[i]   = SAT_MIN[OUT_WIDTH-1:0];
        rq_sat[i] = 1'b1;
      end else begin
        rq_y[i] = r[OUT_WIDTH-1:0];
      end
    end
  end

  logic signed [OUT_WIDTH-1:0] s1_y [0:LENGTH-1];
  logic                        s1_sat;
  act_mode_e                   s1_mode;
  logic [SHIFT_WIDTH-1:0]      s1_leak;
  logic signed [OUT_WIDTH-1:0] s1_clip;

  // S1 register: captures requantised lanes plus the beat's own config.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
      s1_mode  <= MODE_IDENT;
      s1_leak  <= '0;
      s1_clip  <= '0;
      for (int i = 0; i < LENGTH; i++) begin
        s1_y[i] <= '0;
      end
    end else if (s1_adv) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sat  <= |rq_sat;
        s1_mode <= act_mode_e'(mode);
        s1_leak <= leak_shift;
        s1_clip <= clip_max;
        for (int i = 0; i < LENGTH; i++) begin
          s1_y[i] <= rq_y[i];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // S2: activate
  // ------------------------------------------------------------------
  logic signed [OUT_WIDTH-1:0] act_y [0:LENGTH-1];

  // Per-lane activation selected by the mode carried with the beat.
  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      act_y[i] = s1_y[i];
      case (s1_mode)
        MODE_IDENT: act_y[i] = s1_y[i];
        MODE_RELU:  act_y[i] = (s1_y[i] < 0) ? '0 : s1_y[i];
        MODE_LEAKY: act_y[i] = (s1_y[i] < 0) ? (s1_y[i] >>> s1_leak) : s1_y[i];
        MODE_CLAMP: begin
          // A negative bound leaves no valid non-negative output, so 0.
          if (s1_y[i] < 0 || s1_clip < 0) begin
            act_y[i] = '0;
          end else if (s1_y[i] > s1_clip) begin
            act_y[i] = s1_clip;
          end else begin
            act_y[i] = s1_y[i];
          end
        end
        default:    act_y[i] = s1_y[i];
      endcase
    end
  end

  // S2 register: output beat, held stable while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the lane data registers are reset (not just the valids)
      // because the outputs must read 0 straight out of reset.
      s2_valid <= 1'b0;
      out_sat  <= 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
        Out[i] <= '0;
      end
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sat <= s1_sat;
        for (int i = 0; i < LENGTH; i++) begin
          Out[i] <= act_y[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit: a reference model computes the
// expected beat at acceptance and queues it; a monitor pops and compares
// on each output transfer, and also checks stall stability and in_ready.

module tb_activation_unit;

  localparam int IW = 32;
  localparam int OW = 16;
  localparam int L  = 4;
  localparam int SW = 5;
  localparam longint SMAX = (longint'(1) <<< (OW-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (OW-1));

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] in_lanes [0:L-1];
  logic [1:0]           mode_s;
  logic [SW-1:0]        shift_s;
  logic [SW-1:0]        leak_s;
  logic signed [OW-1:0] clip_s;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_lanes [0:L-1];
  logic                 out_sat;

  activation_unit #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LENGTH(L), .SHIFT_WIDTH(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In        (in_lanes),
    .mode      (mode_s),
    .shift     (shift_s),
    .leak_shift(leak_s),
    .clip_max  (clip_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (out_lanes),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint v [0:L-1];
    bit     sat;
    int     acc;
  } exp_t;

  exp_t   sb [$];
  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  bit     check_lat = 1'b1;
  bit     bp_en = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model evaluated from the bench's own driven inputs.
  function automatic exp_t model();
    exp_t   e;
    longint x, r, y, clip;
    e.sat = 1'b0;
    e.acc = cyc;
    clip  = longint'(clip_s);
    for (int i = 0; i < L; i++) begin
      x = longint'(in_lanes[i]);
      if (shift_s == 0) r = x;
      else              r = (x + (longint'(1) << (shift_s - 1))) >>> shift_s;
      if (r > SMAX) begin r = SMAX; e.sat = 1'b1; end
      else if (r < SMIN) begin r = SMIN; e.sat = 1'b1; end
      case (mode_s)
        2'b00: y = r;
        2'b01: y = (r < 0) ? 0 : r;
        2'b10: y = (r < 0) ? (r >>> leak_s) : r;
        default: y = (r < 0 || clip < 0) ? 0 : ((r > clip) ? clip : r);
      endcase
      e.v[i] = y;
    end
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Random downstream backpressure when enabled.
  always @(posedge clk) begin
    #2;
    if (bp_en) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: values seen here are the ones the next rising edge samples.
  bit     prev_stall = 1'b0;
  longint prev_v [0:L-1];
  bit     prev_sat;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_sat", out_sat, prev_sat);
        for (int i = 0; i < L; i++) check($sformatf("stall_lane%0d", i), longint'(out_lanes[i]), prev_v[i]);
      end
      prev_stall = out_valid && !out_ready;
      prev_sat   = out_sat;
      for (int i = 0; i < L; i++) prev_v[i] = longint'(out_lanes[i]);

      check("in_ready", in_ready, !(sb.size() == 2 && !out_ready));

      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          for (int i = 0; i < L; i++) check($sformatf("lane%0d", i), longint'(out_lanes[i]), e.v[i]);
          check("out_sat", out_sat, e.sat);
          if (check_lat) check("latency", cyc - e.acc, 2);
        end
      end
      if (in_valid && in_ready) sb.push_back(model());
    end
  end

  // Drive one beat starting just after a rising edge; returns once accepted.
  task automatic send(input logic [1:0] m, input int sh, input int ls, input int clip,
                      input int l0, input int l1, input int l2, input int l3);
    bit ok;
    int tries;
    mode_s = m; shift_s = SW'(sh); leak_s = SW'(ls); clip_s = OW'(clip);
    in_lanes[0] = l0; in_lanes[1] = l1; in_lanes[2] = l2; in_lanes[3] = l3;
    in_valid = 1'b1;
    tries = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 200);
    if (!ok) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode_s = '0; shift_s = '0; leak_s = '0; clip_s = '0;
    for (int i = 0; i < L; i++) in_lanes[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sat", out_sat, 0);
    for (int i = 0; i < L; i++) check($sformatf("rst_lane%0d", i), longint'(out_lanes[i]), 0);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);

    // ReLU basic stream
    send(2'b01, 0, 0, 0, 5, -3, 0, 32767);
    drain();

    // Mid-stream reset with a beat sitting in the output stage
    send(2'b00, 0, 0, 0, 11, 12, 13, 14);
    send(2'b00, 0, 0, 0, 21, 22, 23, 24);
    check("pre_rst_valid", out_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_sat", out_sat, 0);
    for (int i = 0; i < L; i++) check($sformatf("midrst_lane%0d", i), longint'(out_lanes[i]), 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check("post_rst_no_valid", out_valid, 0);

    // Rounding / saturation
    send(2'b00, 4, 0, 0, 24, -24, 40000000, -40000000);
    send(2'b00, 0, 0, 0, 8, -8, 0, 1);
    send(2'b00, 1, 0, 0, 1, -1, 3, -3);
    send(2'b00, 31, 0, 0, -1, 32'h7fffffff, 32'h80000000, 1073741824);
    // Leaky
    send(2'b10, 0, 3, 0, -16, -1, -9, 100);
    send(2'b10, 0, 0, 0, -16, -1, -9, 100);
    // Clamp
    send(2'b11, 0, 0, 6, -4, 3, 6, 900);
    send(2'b11, 0, 0, -5, -4, 3, 6, 900);
    // Config captured per beat: back-to-back mode change
    send(2'b01, 0, 0, 0, -7, 1, 2, 3);
    send(2'b00, 0, 0, 0, -7, 1, 2, 3);
    drain();

    // Backpressure: distinct back-to-back beats with random out_ready
    check_lat = 1'b0;
    bp_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send(2'($urandom_range(0, 3)), $urandom_range(0, 12), $urandom_range(0, 6),
           $urandom_range(0, 3000) - 500,
           int'($urandom) >>> 8, (k + 1) * 1000, -(k + 1) * 777, int'($urandom));
    end
    drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
